// File: rtl/hamming_dec.sv
// hamming_dec: serial SECDED decoder for 16-bit Hamming packets, MSB first.
// Syndrome and overall parity are accumulated bit by bit. Only the 11 data
// bits are kept; the syndrome selects which data bit (if any) to flip.
// Optional error statistics counters are built when HAMMING_DEC_STATS_EN
// is defined.
module hamming_dec #(
  parameter int unsigned STATS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [10:0]        data_out,
  output logic               out_valid,
  output logic               err_corr,
  output logic               err_uncorr
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [STATS_W-1:0] corr_cnt,
  output logic [STATS_W-1:0] uncorr_cnt
`endif
);

  // Frame accumulators
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  syn_q, syn_d;
  logic        par_q, par_d;
  logic [10:0] dat_q, dat_d;

  // Registered results
  logic [10:0] data_q, data_d;
  logic        ov_q, ov_d;
  logic        corr_q, corr_d;
  logic        uncorr_q, uncorr_d;

  // Per-bit working values
  logic [3:0]  idx_base;
  logic [3:0]  syn_base;
  logic        par_base;
  logic [10:0] dat_base;
  logic [3:0]  pos;
  logic        is_data;
  logic [3:0]  syn_acc;
  logic        par_acc;
  logic [10:0] dat_acc;
  logic [10:0] flip;
  logic [10:0] fixed;

  // A sampled frame_sync restarts the frame, so the bit is treated as packet[15]
  // against cleared accumulators rather than continuing the partial frame.
  always_comb begin
    idx_base = frame_sync ? 4'd15 : idx_q;
    syn_base = frame_sync ? 4'd0  : syn_q;
    par_base = frame_sync ? 1'b0  : par_q;
    dat_base = frame_sync ? '0    : dat_q;

    pos      = 4'd15 - idx_base;
    is_data  = !((idx_base == 4'd15) || (idx_base == 4'd14) ||
                 (idx_base == 4'd13) || (idx_base == 4'd11) ||
                 (idx_base == 4'd7));

    syn_acc  = syn_base ^ ((din && (idx_base != 4'd15)) ? pos : 4'd0);
    par_acc  = par_base ^ din;
    dat_acc  = is_data ? {dat_base[9:0], din} : dat_base;
  end

  // Map a syndrome (Hamming position) onto the data bit it covers; parity
  // positions 1, 2, 4, 8 carry no data and produce no flip.
  always_comb begin
    flip = '0;
    case (syn_acc)
      4'd3:    flip = 11'h400;
      4'd5:    flip = 11'h200;
      4'd6:    flip = 11'h100;
      4'd7:    flip = 11'h080;
      4'd9:    flip = 11'h040;
      4'd10:   flip = 11'h020;
      4'd11:   flip = 11'h010;
      4'd12:   flip = 11'h008;
      4'd13:   flip = 11'h004;
      4'd14:   flip = 11'h002;
      4'd15:   flip = 11'h001;
      default: flip = '0;
    endcase
    fixed = par_acc ? (dat_acc ^ flip) : dat_acc;
  end

  // Next-state: accept a bit, complete a frame, or abort on a bare frame_sync.
  always_comb begin
    idx_d    = idx_q;
    syn_d    = syn_q;
    par_d    = par_q;
    dat_d    = dat_q;
    data_d   = data_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    ov_d     = 1'b0;

    if (din_valid) begin
      if (idx_base == 4'd0) begin
        idx_d    = 4'd15;
        syn_d    = '0;
        par_d    = 1'b0;
        dat_d    = '0;
        data_d   = fixed;
        corr_d   = par_acc;
        uncorr_d = !par_acc && (syn_acc != 4'd0);
        ov_d     = 1'b1;
      end else begin
        idx_d = idx_base - 4'd1;
        syn_d = syn_acc;
        par_d = par_acc;
        dat_d = dat_acc;
      end
    end else if (frame_sync) begin
      idx_d = 4'd15;
      syn_d = '0;
      par_d = 1'b0;
      dat_d = '0;
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 4'd15;
      syn_q    <= '0;
      par_q    <= 1'b0;
      dat_q    <= '0;
      data_q   <= '0;
      ov_q     <= 1'b0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      syn_q    <= syn_d;
      par_q    <= par_d;
      dat_q    <= dat_d;
      data_q   <= data_d;
      ov_q     <= ov_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign data_out   = data_q;
  assign out_valid  = ov_q;
  assign err_corr   = corr_q;
  assign err_uncorr = uncorr_q;

`ifdef HAMMING_DEC_STATS_EN
  logic [STATS_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [STATS_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  // Saturating counters, advanced on the cycle the result is presented.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (ov_q && corr_q && (corr_cnt_q != '1))
      corr_cnt_d = corr_cnt_q + 1'b1;
    if (ov_q && uncorr_q && (uncorr_cnt_q != '1))
      uncorr_cnt_d = uncorr_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  // Counter width has no effect when statistics are not built.
  if (STATS_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_hamming_dec.sv
// Directed testbench for hamming_dec.
module tb_hamming_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        frame_sync;
  logic [10:0] data_out;
  logic        out_valid;
  logic        err_corr;
  logic        err_uncorr;
`ifdef HAMMING_DEC_STATS_EN
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ov_count = 0;

  hamming_dec #(.STATS_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) ov_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Reference encoder: data placement plus parity over Hamming positions.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] p;
    logic        par;
    int unsigned k;
    p = '0;
    p[12]   = d[10];
    p[10:8] = d[9:7];
    p[6:0]  = d[6:0];
    for (int b = 0; b < 4; b++) begin
      k = 1 << b;
      par = 1'b0;
      for (int j = 1; j < 16; j++)
        if (((j & k) != 0) && (j != k)) par ^= p[15-j];
      p[15-k] = par;
    end
    p[15] = ^p[14:0];
    return p;
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    @(negedge clk);
    din = b; din_valid = 1'b1; frame_sync = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    end
  endtask

  // Shift a packet MSB first, then stop #1 after the edge taking the last bit.
  task automatic run_frame(input logic [15:0] pkt, input bit gaps);
    for (int i = 15; i >= 0; i--) begin
      if (gaps) idle($urandom_range(0, 2));
      send_bit(pkt[i], 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    #13;
    checks++;
    if ({data_out, out_valid, err_corr, err_uncorr} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h ov=%b c=%b u=%b, want all 0",
               data_out, out_valid, err_corr, err_uncorr);
    end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_clean;
    int base;
    base = ov_count;
    run_frame(encode(11'h5A3), 1'b0);
    checks++;
    if ({out_valid, data_out, err_corr, err_uncorr} !== {1'b1, 11'h5A3, 2'b00}) begin
      errors++;
      $display("FAIL clean: got ov=%b data=%h c=%b u=%b, want ov=1 data=5a3 c=0 u=0",
               out_valid, data_out, err_corr, err_uncorr);
    end
    idle(1);
    @(posedge clk); #1;
    checks++;
    if ({out_valid, data_out} !== {1'b0, 11'h5A3}) begin
      errors++;
      $display("FAIL clean_hold: got ov=%b data=%h, want ov=0 data=5a3", out_valid, data_out);
    end
    checks++;
    if (ov_count - base !== 1) begin
      errors++;
      $display("FAIL clean_pulses: got %0d, want 1", ov_count - base);
    end
  endtask

  // Sixteen single-error frames sent back to back.
  task automatic test_back_to_back;
    logic [15:0] mask;
    int base;
    base = ov_count;
    for (int i = 0; i < 16; i++) begin
      mask = 16'd1 << i;
      run_frame(encode(11'h2C7) ^ mask, 1'b0);
      checks++;
      if ({out_valid, data_out, err_corr, err_uncorr} !== {1'b1, 11'h2C7, 2'b10}) begin
        errors++;
        $display("FAIL single_err[%0d]: got ov=%b data=%h c=%b u=%b, want ov=1 data=2c7 c=1 u=0",
                 i, out_valid, data_out, err_corr, err_uncorr);
      end
    end
    idle(2);
    checks++;
    if (ov_count - base !== 16) begin
      errors++;
      $display("FAIL sweep_pulses: got %0d, want 16", ov_count - base);
    end
  endtask

  task automatic test_double;
    run_frame(encode(11'h7FF) ^ 16'h0208, 1'b0);
    checks++;
    if ({out_valid, data_out, err_corr, err_uncorr} !== {1'b1, 11'h6F7, 2'b01}) begin
      errors++;
      $display("FAIL double_err: got ov=%b data=%h c=%b u=%b, want ov=1 data=6f7 c=0 u=1",
               out_valid, data_out, err_corr, err_uncorr);
    end
    idle(2);
  endtask

  task automatic test_sync_abort;
    logic [15:0] pkt;
    int base;
    base = ov_count;
    pkt = encode(11'h3AB);
    for (int i = 15; i > 8; i--) send_bit(pkt[i], 1'b0);
    idle(1);
    @(negedge clk); din_valid = 1'b0; frame_sync = 1'b1;
    idle(2);
    checks++;
    if (ov_count - base !== 0) begin
      errors++;
      $display("FAIL abort_no_pulse: got %0d pulses, want 0", ov_count - base);
    end
    run_frame(encode(11'h001), 1'b1);
    checks++;
    if ({out_valid, data_out, err_corr, err_uncorr} !== {1'b1, 11'h001, 2'b00}) begin
      errors++;
      $display("FAIL stall_frame: got ov=%b data=%h c=%b u=%b, want ov=1 data=001 c=0 u=0",
               out_valid, data_out, err_corr, err_uncorr);
    end
    // frame_sync together with din_valid restarts on the sampled bit
    pkt = encode(11'h0AA);
    for (int i = 15; i > 10; i--) send_bit(pkt[i], 1'b0);
    pkt = encode(11'h4D2);
    send_bit(pkt[15], 1'b1);
    for (int i = 14; i >= 0; i--) send_bit(pkt[i], 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({out_valid, data_out, err_corr, err_uncorr} !== {1'b1, 11'h4D2, 2'b00}) begin
      errors++;
      $display("FAIL sync_with_valid: got ov=%b data=%h c=%b u=%b, want ov=1 data=4d2 c=0 u=0",
               out_valid, data_out, err_corr, err_uncorr);
    end
    idle(2);
    checks++;
    if (ov_count - base !== 2) begin
      errors++;
      $display("FAIL abort_pulses: got %0d, want 2", ov_count - base);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] pkt;
    int base;
    base = ov_count;
    pkt = encode(11'h155);
    for (int i = 15; i > 5; i--) send_bit(pkt[i], 1'b0);
    @(negedge clk); din_valid = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, out_valid, err_corr, err_uncorr} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid: got data=%h ov=%b c=%b u=%b, want all 0",
               data_out, out_valid, err_corr, err_uncorr);
    end
    idle(1);
    @(negedge clk); rst_n = 1'b1;
    run_frame(encode(11'h63C) ^ 16'h0010, 1'b0);
    checks++;
    if ({out_valid, data_out, err_corr, err_uncorr} !== {1'b1, 11'h63C, 2'b10}) begin
      errors++;
      $display("FAIL after_reset: got ov=%b data=%h c=%b u=%b, want ov=1 data=63c c=1 u=0",
               out_valid, data_out, err_corr, err_uncorr);
    end
    idle(2);
    checks++;
    if (ov_count - base !== 1) begin
      errors++;
      $display("FAIL reset_pulses: got %0d, want 1", ov_count - base);
    end
  endtask

`ifdef HAMMING_DEC_STATS_EN
  task automatic test_stats;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if ({corr_cnt, uncorr_cnt} !== 4'h0) begin
      errors++;
      $display("FAIL stats_reset: got c=%0d u=%0d, want 0 0", corr_cnt, uncorr_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_frame(encode(11'h2C7) ^ (16'd1 << (i * 3)), 1'b0);
    idle(2);
    checks++;
    if ({corr_cnt, uncorr_cnt} !== {2'd3, 2'd0}) begin
      errors++;
      $display("FAIL stats_sat: got c=%0d u=%0d, want 3 0", corr_cnt, uncorr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_back_to_back();
    test_double();
    test_sync_abort();
    test_reset_mid();
`ifdef HAMMING_DEC_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
